// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, entry struct and skid FSM states for alu_result_stage
package alu_pkg;
  localparam int DEF_REG_SIZE = 32;
  localparam int DEF_REG_IDX_W = 5;
  typedef struct packed {
    logic [DEF_REG_SIZE-1:0] result;
    logic [DEF_REG_IDX_W-1:0] rd;
    logic we;
    logic zero;
  } alu_res_t;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_e;
endpackage

// File: rtl/alu_result_stage_skid_buffer.sv
// skid_buffer: generic 2-entry valid/ready buffer, main entry drives outputs, skid entry absorbs one stall
module skid_buffer
  import alu_pkg::*;
#(
  parameter int W = 8,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);
  skid_state_e state_q, state_d;
  logic [W-1:0] m_q, m_d, s_q, s_d;
  assign in_ready_o = state_q != TWO;
  assign out_valid_o = state_q != EMPTY;
  assign out_data_o = m_q;
  always_comb begin
    state_d = state_q;
    m_d = m_q;
    s_d = s_q;
    case (state_q)
      EMPTY: if (in_valid_i) begin
        m_d = in_data_i;
        state_d = ONE;
      end
      ONE: if (in_valid_i && out_ready_i) m_d = in_data_i;
      else if (in_valid_i) begin
        s_d = in_data_i;
        state_d = TWO;
      end
      else if (out_ready_i) state_d = EMPTY;
      TWO: if (out_ready_i) begin
        m_d = s_q;
        state_d = ONE;
      end
      default: state_d = EMPTY;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      m_q <= RST;
      s_q <= RST;
    end else begin
      state_q <= state_d;
      m_q <= m_d;
      s_q <= s_d;
    end
  end
endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: EX/MEM stage capturing ALU result, rd, we and zero flag through a skid buffer; ALU_RESULT_FWD_EN adds fwd_* bypass outputs
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int REG_SIZE = DEF_REG_SIZE,
  parameter int REG_IDX_W = DEF_REG_IDX_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [REG_SIZE-1:0]  in_result,
  input  logic [REG_IDX_W-1:0] in_rd,
  input  logic                 in_we,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [REG_SIZE-1:0]  out_result,
  output logic [REG_IDX_W-1:0] out_rd,
  output logic                 out_we,
`ifdef ALU_RESULT_FWD_EN
  output logic                 fwd_valid,
  output logic [REG_IDX_W-1:0] fwd_rd,
  output logic [REG_SIZE-1:0]  fwd_result,
`endif
  output logic                 out_zero
);
  localparam alu_res_t RST_ENTRY = '{result: '0, rd: '0, we: 1'b0, zero: 1'b1};
  alu_res_t in_d, m_q;
  always_comb begin
    in_d.result = in_result;
    in_d.rd = in_rd;
    in_d.we = in_we && (in_rd != '0);
    in_d.zero = in_result == '0;
  end
  skid_buffer #(.W($bits(alu_res_t)), .RST(RST_ENTRY)) u_skid (
    .clk(clk),
    .rst(rst),
    .in_valid_i(in_valid),
    .in_ready_o(in_ready),
    .in_data_i(in_d),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o(m_q)
  );
  assign out_result = m_q.result;
  assign out_rd = m_q.rd;
  assign out_we = m_q.we;
  assign out_zero = m_q.zero;
`ifdef ALU_RESULT_FWD_EN
  assign fwd_valid = out_valid && m_q.we;
  assign fwd_rd = m_q.rd;
  assign fwd_result = m_q.result;
`endif
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed and scoreboarded checks of alu_result_stage
module tb_alu_result_stage;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, in_we = 0, out_valid, out_ready = 0, out_we, out_zero;
  logic [31:0] in_result = 0, out_result;
  logic [4:0] in_rd = 0, out_rd;
`ifdef ALU_RESULT_FWD_EN
  logic fwd_valid;
  logic [4:0] fwd_rd;
  logic [31:0] fwd_result;
`endif
  int total = 0, bad = 0;
  alu_result_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_rd(in_rd), .in_we(in_we),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd), .out_we(out_we),
`ifdef ALU_RESULT_FWD_EN
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_result(fwd_result),
`endif
    .out_zero(out_zero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] r, input logic [4:0] d, input logic w);
    in_valid = v;
    in_result = r;
    in_rd = d;
    in_we = w;
  endtask
  initial begin
    logic [37:0] q[$];
    logic [37:0] exp_e, snap;
    logic stalled;
    int sent, rcv;
    logic [31:0] vr;
    logic [4:0] vd;
    logic vw;
    drive(1, 32'h5, 5'd1, 1);
    step();
    step();
    chk("rst_valid", out_valid, 0);
    chk("rst_zero", out_zero, 1);
    chk("rst_ready", in_ready, 1);
    chk("rst_result", out_result, 0);
    chk("rst_we", out_we, 0);
    rst = 0;
    drive(0, 0, 0, 0);
    step();
    chk("idle_valid", out_valid, 0);
    drive(1, 32'hDEADBEEF, 5'd3, 1);
    out_ready = 1;
    step();
    drive(0, 0, 0, 0);
    chk("one_valid", out_valid, 1);
    chk("one_result", out_result, 32'hDEADBEEF);
    chk("one_rd", out_rd, 3);
    chk("one_we", out_we, 1);
    chk("one_zero", out_zero, 0);
    step();
    chk("one_drained", out_valid, 0);
    out_ready = 0;
    drive(1, 1, 5'd1, 1);
    step();
    drive(1, 2, 5'd2, 1);
    step();
    drive(1, 3, 5'd3, 1);
    chk("b2b_hold1", out_result, 1);
    chk("b2b_full", in_ready, 0);
    step();
    chk("b2b_still1", out_result, 1);
    chk("b2b_still_full", in_ready, 0);
    out_ready = 1;
    step();
    chk("b2b_out2", out_result, 2);
    chk("b2b_ready", in_ready, 1);
    step();
    drive(0, 0, 0, 0);
    chk("b2b_out3", out_result, 3);
    chk("b2b_valid3", out_valid, 1);
    step();
    chk("b2b_empty", out_valid, 0);
    out_ready = 0;
    drive(1, 0, 5'd0, 1);
    step();
    drive(0, 0, 0, 0);
    chk("z_valid", out_valid, 1);
    chk("z_zero", out_zero, 1);
    chk("z_we", out_we, 0);
    out_ready = 1;
    step();
    sent = 0;
    rcv = 0;
    vr = $urandom;
    vd = 5'($urandom_range(0, 31));
    vw = 1'($urandom_range(0, 1));
    for (int c = 0; c < 1000 && rcv < 100; c++) begin
      out_ready = c[0];
      drive(sent < 100, vr, vd, vw);
      if (in_valid && in_ready) begin
        q.push_back({vr, vd, vw && vd != 0});
        sent++;
        vr = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
        vd = 5'($urandom_range(0, 31));
        vw = 1'($urandom_range(0, 1));
      end
      stalled = out_valid && !out_ready;
      snap = {out_result, out_rd, out_we};
      if (out_valid && out_ready) begin
        exp_e = q.size() > 0 ? q.pop_front() : 38'h3f_ffff_ffff;
        chk("rnd_data", {out_result, out_rd, out_we}, exp_e);
        chk("rnd_zero", out_zero, exp_e[37:6] == 0);
        rcv++;
      end
      step();
      if (stalled) chk("rnd_stable", {out_valid, out_result, out_rd, out_we}, {1'b1, snap});
    end
    chk("rnd_count", rcv, 100);
    drive(0, 0, 0, 0);
    out_ready = 0;
    step();
    drive(1, 9, 5'd2, 1);
    step();
    step();
    chk("two_full", in_ready, 0);
    rst = 1;
    step();
    rst = 0;
    drive(0, 0, 0, 0);
    chk("rst2_valid", out_valid, 0);
    chk("rst2_ready", in_ready, 1);
    chk("rst2_zero", out_zero, 1);
    drive(1, 32'h55, 5'd7, 1);
    step();
    drive(0, 0, 0, 0);
    chk("f_rd", out_rd, 7);
    chk("f_we", out_we, 1);
`ifdef ALU_RESULT_FWD_EN
    chk("f_valid", fwd_valid, 1);
    chk("f_rd_fwd", fwd_rd, 7);
    chk("f_result", fwd_result, 32'h55);
`endif
    out_ready = 1;
    step();
    chk("f_drained", out_valid, 0);
`ifdef ALU_RESULT_FWD_EN
    chk("f_valid_off", fwd_valid, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
